// File: rtl/layer_mac_scheduler_pkg.sv
// Shared types and arithmetic helpers for the layer MAC scheduler.
// Helpers work on 64-bit signed values, so DW must be 32 or less.
package layer_pkg;

    localparam int DW_DEFAULT = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MAC,
        ST_BIAS,
        ST_OUT,
        ST_DONE
    } layer_state_e;

    // Reinterpret the low w bits of v as a signed w-bit number.
    function automatic longint sext(input longint v, input int unsigned w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint sat_clamp(input longint v, input int unsigned w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input int unsigned w);
        return sat_clamp(a + b, w);
    endfunction

    function automatic longint sat_mul(input longint a, input longint b, input int unsigned w);
        return sat_clamp(a * b, w);
    endfunction

endpackage

// File: rtl/layer_mac_scheduler_if.sv
// Handshake, memory-read and result bus of the layer MAC scheduler.
interface layer_mac_scheduler_if #(
    parameter int NUM_IN  = 10,
    parameter int NUM_OUT = 16,
    parameter int DW      = layer_pkg::DW_DEFAULT
);
    localparam int AW  = $clog2(NUM_IN);
    localparam int WAW = $clog2(NUM_IN * NUM_OUT);
    localparam int OW  = $clog2(NUM_OUT);

    logic           start;
    logic           busy;
    logic           done;
    logic [AW-1:0]  act_addr;
    logic [DW-1:0]  act_data;
    logic [WAW-1:0] wt_addr;
    logic [DW-1:0]  wt_data;
    logic [DW-1:0]  bias_data;
    logic           out_valid;
    logic           out_ready;
    logic [OW-1:0]  out_idx;
    logic [DW-1:0]  out_data;

    modport master (
        output start, act_data, wt_data, bias_data, out_ready,
        input  busy, done, act_addr, wt_addr, out_valid, out_idx, out_data
    );

    modport slave (
        input  start, act_data, wt_data, bias_data, out_ready,
        output busy, done, act_addr, wt_addr, out_valid, out_idx, out_data
    );

endinterface

// File: rtl/layer_mac_scheduler_mac_unit.sv
// Shared multiply-accumulate datapath: product, accumulate, bias add and ReLU.
// Define LAYER_SAT_EN to saturate products and sums instead of wrapping.
module mac_unit
    import layer_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          mac_en,
    input  logic          bias_en,
    input  logic [DW-1:0] act_data,
    input  logic [DW-1:0] wt_data,
    input  logic [DW-1:0] bias_data,
    output logic [DW-1:0] relu_out
);
    localparam int unsigned W = DW;

    logic [DW-1:0] acc;
    logic [DW-1:0] acc_n;
    longint        a_s;
    longint        w_s;
    longint        b_s;
    longint        acc_s;
    longint        prod;
    longint        addend;
    longint        sum;

    always_comb begin
        a_s   = sext(longint'(act_data), W);
        w_s   = sext(longint'(wt_data), W);
        b_s   = sext(longint'(bias_data), W);
        acc_s = sext(longint'(acc), W);
`ifdef LAYER_SAT_EN
        prod   = sat_mul(a_s, w_s, W);
        addend = mac_en ? prod : b_s;
        sum    = sat_add(acc_s, addend, W);
`else
        prod   = sext(a_s * w_s, W);
        addend = mac_en ? prod : b_s;
        sum    = acc_s + addend;
`endif
        acc_n = DW'(sum);
    end

    always_ff @(posedge clk) begin
        if (reset || clear)
            acc <= '0;
        else if (mac_en || bias_en)
            acc <= acc_n;
    end

    assign relu_out = acc[DW-1] ? '0 : acc;

endmodule

// File: rtl/layer_mac_scheduler.sv
// Sequences NUM_OUT neurons of NUM_IN inputs each through one shared MAC.
// Optional build macro LAYER_SAT_EN selects saturating arithmetic in mac_unit.
module layer_mac_scheduler
    import layer_pkg::*;
#(
    parameter int NUM_IN  = 10,
    parameter int NUM_OUT = 16,
    parameter int DW      = DW_DEFAULT
) (
    input logic                  clk,
    input logic                  reset,
    layer_mac_scheduler_if.slave bus
);
    localparam int AW  = $clog2(NUM_IN);
    localparam int WAW = $clog2(NUM_IN * NUM_OUT);
    localparam int OW  = $clog2(NUM_OUT);
    localparam int CW  = $clog2(NUM_IN + 1);

    layer_state_e  state;
    layer_state_e  state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [OW-1:0] idx;
    logic [OW-1:0] idx_n;
    logic          clear;
    logic          mac_en;
    logic          bias_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // MAC lasts NUM_IN+1 cycles: reads issue on cnt 0..NUM_IN-1, products land on cnt 1..NUM_IN.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        clear   = 1'b0;
        mac_en  = 1'b0;
        bias_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_n = ST_MAC;
                    cnt_n   = '0;
                    idx_n   = '0;
                    clear   = 1'b1;
                end
            end
            ST_MAC: begin
                mac_en = (cnt != '0);
                if (cnt == CW'(NUM_IN)) begin
                    state_n = ST_BIAS;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            ST_BIAS: begin
                bias_en = 1'b1;
                state_n = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    if (idx == OW'(NUM_OUT - 1)) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_MAC;
                        idx_n   = idx + OW'(1);
                        cnt_n   = '0;
                        clear   = 1'b1;
                    end
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.act_addr = '0;
        bus.wt_addr  = '0;
        if (state == ST_MAC && cnt < CW'(NUM_IN)) begin
            bus.act_addr = AW'(cnt);
            bus.wt_addr  = WAW'(int'(idx) * NUM_IN + int'(cnt));
        end
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.out_valid = (state == ST_OUT);
    assign bus.out_idx   = idx;

    mac_unit #(.DW(DW)) u_mac (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .mac_en    (mac_en),
        .bias_en   (bias_en),
        .act_data  (bus.act_data),
        .wt_data   (bus.wt_data),
        .bias_data (bus.bias_data),
        .relu_out  (bus.out_data)
    );

endmodule
